// File: rtl/field_sel_pkg.sv
// Shared constants and state encoding for the field selector.
package field_sel_pkg;

    localparam int unsigned WRAP_SAT  = 0;
    localparam int unsigned WRAP_ROLL = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SELECT = 1'b1
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for a button level.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic lvl,
    output logic rise
);

    logic lvl_q, lvl_d;
    logic armed_q, armed_d;
    logic rise_q, rise_d;

    // armed_q blocks a level already high at reset release from looking like a press.
    always_comb begin
        lvl_d   = lvl;
        armed_d = 1'b1;
        rise_d  = armed_q & lvl & ~lvl_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lvl_q   <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            armed_q <= armed_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/field_selector.sv
// Cursor over MAX_POS fields stepped by inc/dec buttons, with one-hot select and blink.
module field_selector
    import field_sel_pkg::*;
#(
    parameter int unsigned MAX_POS   = 8,
    parameter int unsigned WRAP      = 1,
    parameter int unsigned BLINK_DIV = 25000000,
    localparam int unsigned POS_W    = $clog2(MAX_POS)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               active,
    input  logic               inc,
    input  logic               dec,
    input  logic [POS_W:0]     max,
    input  logic               blink_en,
    output logic [POS_W-1:0]   count_val,
    output logic [MAX_POS-1:0] out,
    output logic               wrapped,
    output logic               blink_phase
);

    localparam int unsigned BW = $clog2(BLINK_DIV);

    logic inc_req, dec_req;

    rise_detect u_inc_rise (
        .clk    (clk),
        .resetn (resetn),
        .lvl    (inc),
        .rise   (inc_req)
    );

    rise_detect u_dec_rise (
        .clk    (clk),
        .resetn (resetn),
        .lvl    (dec),
        .rise   (dec_req)
    );

    state_e           state_q, state_d;
    logic [POS_W-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             phase_q, phase_d;

    logic [POS_W:0] lim;
    logic [POS_W:0] last;
    logic [POS_W:0] count_ext;

    always_comb begin
        if (max == '0) begin
            lim = (POS_W+1)'(1);
        end else if (max > (POS_W+1)'(MAX_POS)) begin
            lim = (POS_W+1)'(MAX_POS);
        end else begin
            lim = max;
        end
        last      = lim - (POS_W+1)'(1);
        count_ext = {1'b0, count_q};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wrapped_d = 1'b0;
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;

        unique case (state_q)
            IDLE: begin
                bcnt_d  = '0;
                phase_d = 1'b1;
                if (active) begin
                    state_d = SELECT;
                    count_d = '0;
                end
            end
            SELECT: begin
                if (!active) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                    phase_d = 1'b1;
                end else begin
                    // A run-time shrink of max pulls the cursor home before any step.
                    if (count_ext >= lim) begin
                        count_d = '0;
                    end else if (inc_req && !dec_req) begin
                        if (count_ext < last) begin
                            count_d = count_q + POS_W'(1);
                        end else if (WRAP == WRAP_ROLL) begin
                            count_d   = '0;
                            wrapped_d = 1'b1;
                        end
                    end else if (dec_req && !inc_req) begin
                        if (count_q != '0) begin
                            count_d = count_q - POS_W'(1);
                        end else if (WRAP == WRAP_ROLL) begin
                            count_d   = last[POS_W-1:0];
                            wrapped_d = 1'b1;
                        end
                    end

                    if (count_d != count_q || !blink_en) begin
                        bcnt_d  = '0;
                        phase_d = 1'b1;
                    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                        bcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            bcnt_q    <= '0;
            phase_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
        end
    end

    assign count_val   = count_q;
    assign wrapped     = wrapped_q;
    assign blink_phase = phase_q;
    assign out         = (state_q == SELECT && phase_q) ? (MAX_POS'(1) << count_q) : '0;

endmodule

// File: tb/tb_field_selector.sv
// Directed bench: one wrapping and one saturating instance driven by the same buttons.
module tb_field_selector;

    localparam int unsigned MP = 8;
    localparam int unsigned BD = 4;

    logic       clk;
    logic       resetn;
    logic       active;
    logic       inc;
    logic       dec;
    logic [3:0] max;
    logic       blink_en;

    logic [2:0] cv_w, cv_s;
    logic [7:0] out_w, out_s;
    logic       wr_w, wr_s;
    logic       bp_w, bp_s;

    int checks;
    int failures;

    field_selector #(.MAX_POS(MP), .WRAP(1), .BLINK_DIV(BD)) dut_wrap (
        .clk         (clk),
        .resetn      (resetn),
        .active      (active),
        .inc         (inc),
        .dec         (dec),
        .max         (max),
        .blink_en    (blink_en),
        .count_val   (cv_w),
        .out         (out_w),
        .wrapped     (wr_w),
        .blink_phase (bp_w)
    );

    field_selector #(.MAX_POS(MP), .WRAP(0), .BLINK_DIV(BD)) dut_sat (
        .clk         (clk),
        .resetn      (resetn),
        .active      (active),
        .inc         (inc),
        .dec         (dec),
        .max         (max),
        .blink_en    (blink_en),
        .count_val   (cv_s),
        .out         (out_s),
        .wrapped     (wr_s),
        .blink_phase (bp_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inc();
        inc = 1'b1;
        tick();
        inc = 1'b0;
        tick();
    endtask

    task automatic pulse_dec();
        dec = 1'b1;
        tick();
        dec = 1'b0;
        tick();
    endtask

    task automatic reenter();
        active = 1'b0;
        tick();
        active = 1'b1;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b1;
        active   = 1'b0;
        inc      = 1'b0;
        dec      = 1'b0;
        max      = 4'd8;
        blink_en = 1'b0;

        #1 resetn = 1'b0;
        #1;
        check_eq("rst_count", 32'(cv_w), 32'd0);
        check_eq("rst_out", 32'(out_w), 32'h00);
        check_eq("rst_wrapped", 32'(wr_w), 32'd0);
        check_eq("rst_phase", 32'(bp_w), 32'd1);
        #10 resetn = 1'b1;
        tick();

        // Wrap with L = 6
        max    = 4'd6;
        active = 1'b1;
        tick();
        check_eq("enter_count", 32'(cv_w), 32'd0);
        check_eq("enter_out", 32'(out_w), 32'h01);
        for (int i = 0; i < 6; i++) begin
            pulse_inc();
            check_eq("wrap_count", 32'(cv_w), 32'((i + 1) % 6));
            check_eq("wrap_pulse", 32'(wr_w), (i == 5) ? 32'd1 : 32'd0);
            check_eq("sat_l6_count", 32'(cv_s), (i < 5) ? 32'(i + 1) : 32'd5);
            check_eq("sat_l6_pulse", 32'(wr_s), 32'd0);
        end
        check_eq("wrap_out", 32'(out_w), 32'h01);
        tick();
        check_eq("wrap_pulse_one_cycle", 32'(wr_w), 32'd0);

        // Saturate at both ends with L = 8
        max = 4'd8;
        reenter();
        pulse_dec();
        check_eq("sat_dec0_count", 32'(cv_s), 32'd0);
        check_eq("sat_dec0_pulse", 32'(wr_s), 32'd0);
        check_eq("wrap_dec0_count", 32'(cv_w), 32'd7);
        check_eq("wrap_dec0_pulse", 32'(wr_w), 32'd1);
        for (int i = 0; i < 9; i++) begin
            pulse_inc();
            check_eq("sat_inc_count", 32'(cv_s), (i < 7) ? 32'(i + 1) : 32'd7);
            check_eq("sat_inc_pulse", 32'(wr_s), 32'd0);
        end

        // Held button gives one step; simultaneous requests cancel
        reenter();
        inc = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        inc = 1'b0;
        tick();
        check_eq("held_count_w", 32'(cv_w), 32'd1);
        check_eq("held_count_s", 32'(cv_s), 32'd1);
        inc = 1'b1;
        dec = 1'b1;
        tick();
        inc = 1'b0;
        dec = 1'b0;
        tick();
        check_eq("both_count", 32'(cv_w), 32'd1);
        check_eq("both_pulse", 32'(wr_w), 32'd0);

        // Run-time shrink of max
        for (int i = 0; i < 4; i++) pulse_inc();
        check_eq("pre_shrink", 32'(cv_w), 32'd5);
        max = 4'd3;
        tick();
        check_eq("shrink_count_w", 32'(cv_w), 32'd0);
        check_eq("shrink_count_s", 32'(cv_s), 32'd0);
        check_eq("shrink_pulse", 32'(wr_w), 32'd0);
        max = 4'd0;
        pulse_inc();
        check_eq("max0_count_w", 32'(cv_w), 32'd0);
        check_eq("max0_count_s", 32'(cv_s), 32'd0);
        check_eq("max0_pulse_s", 32'(wr_s), 32'd0);

        // Blink with half-period 4
        max      = 4'd8;
        blink_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_eq("blink_phase", 32'(bp_w), ((k / 4) % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("blink_out", 32'(out_w), ((k / 4) % 2 == 0) ? 32'h01 : 32'h00);
        end
        pulse_inc();
        check_eq("blink_step_count", 32'(cv_w), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check_eq("blink_step_visible", 32'(out_w), 32'h02);
            tick();
        end
        check_eq("blink_step_hidden", 32'(out_w), 32'h00);

        // Asynchronous reset mid-blink, released with inc held
        pulse_inc();
        pulse_inc();
        tick();
        tick();
        check_eq("pre_reset_count", 32'(cv_w), 32'd3);
        #3 resetn = 1'b0;
        #1;
        check_eq("async_count", 32'(cv_w), 32'd0);
        check_eq("async_out", 32'(out_w), 32'h00);
        check_eq("async_wrapped", 32'(wr_w), 32'd0);
        check_eq("async_phase", 32'(bp_w), 32'd1);
        check_eq("async_count_s", 32'(cv_s), 32'd0);
        inc = 1'b1;
        #2 resetn = 1'b1;
        tick();
        tick();
        tick();
        check_eq("release_held_count", 32'(cv_w), 32'd0);
        check_eq("release_held_out", 32'(out_w), 32'h01);
        inc = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
